// File: rtl/result_fetch.sv
// Result read-back engine: issues one DataMover MM2S command per start code, filters the
// returned softmax words and streams surviving keypoints with their cell index.
module result_fetch #(
   parameter logic [31:0] SRC_ADDR   = 32'h7000_0000,
   parameter int          NUM_WORDS  = 4800,
   parameter logic [15:0] THRESH     = 16'h0100,
   parameter logic [7:0]  DUSTBIN_ID = 8'd64,
   parameter logic [31:0] START_CODE = 32'h0000_00BB
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] gpio_io_i,
   output logic [31:0] gpio_io_o,
   output logic        m_axis_mm2s_cmd_tvalid,
   input  logic        m_axis_mm2s_cmd_tready,
   output logic [71:0] m_axis_mm2s_cmd_tdata,
   input  logic [31:0] s_axis_mm2s_tdata,
   input  logic        s_axis_mm2s_tvalid,
   input  logic        s_axis_mm2s_tlast,
   output logic        s_axis_mm2s_tready,
   output logic [39:0] m_axis_kp_tdata,
   output logic        m_axis_kp_tvalid,
   input  logic        m_axis_kp_tready
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CMD    = 3'd1;
   localparam logic [2:0] ST_STREAM = 3'd2;
   localparam logic [2:0] ST_DRAIN  = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam logic [22:0] BTT      = 23'(NUM_WORDS * 4);
   localparam logic [12:0] LAST_IDX = 13'(NUM_WORDS - 1);
   localparam logic [12:0] KP_MAX   = 13'h1FFF;

   logic [2:0]  state_q, state_d;
   logic [12:0] word_cnt_q, word_cnt_d;
   logic [12:0] kp_count_q, kp_count_d;
   logic        err_len_q, err_len_d;
   logic        kp_valid_q, kp_valid_d;
   logic [39:0] kp_data_q, kp_data_d;

   logic wordAccept;
   logic wordKeep;
   logic atLastIdx;
   logic frameEnd;
   logic busy;
   logic done;
   logic unusedTdataHi;

   // Upper byte of each result word carries nothing useful.
   assign unusedTdataHi = ^s_axis_mm2s_tdata[31:24];

   // {DRR, EOF, DSA=0, INCR, BTT} with the buffer address above and a zero tag/reserved byte.
   assign m_axis_mm2s_cmd_tdata  = {8'h00, SRC_ADDR, 1'b1, 1'b1, 6'b0, 1'b1, BTT};
   assign m_axis_mm2s_cmd_tvalid = (state_q == ST_CMD);

   assign s_axis_mm2s_tready = (state_q == ST_STREAM) && (!kp_valid_q || m_axis_kp_tready);
   assign wordAccept = s_axis_mm2s_tvalid && s_axis_mm2s_tready;
   assign wordKeep   = (s_axis_mm2s_tdata[23:16] != DUSTBIN_ID) &&
                       (s_axis_mm2s_tdata[15:0] >= THRESH);
   assign atLastIdx  = (word_cnt_q == LAST_IDX);
   assign frameEnd   = wordAccept && (s_axis_mm2s_tlast || atLastIdx);

   assign busy = (state_q == ST_CMD) || (state_q == ST_STREAM) || (state_q == ST_DRAIN);
   assign done = (state_q == ST_DONE);

   assign gpio_io_o        = {3'b0, kp_count_q, 13'b0, err_len_q, done, busy};
   assign m_axis_kp_tdata  = kp_data_q;
   assign m_axis_kp_tvalid = kp_valid_q;

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      kp_count_d = kp_count_q;
      err_len_d  = err_len_q;
      kp_valid_d = kp_valid_q;
      kp_data_d  = kp_data_q;

      if (gpio_io_i == 32'd0) begin
         state_d    = ST_IDLE;
         word_cnt_d = '0;
         kp_count_d = '0;
         err_len_d  = 1'b0;
         kp_valid_d = 1'b0;
         kp_data_d  = '0;
      end else begin
         // A pending keypoint releases on its handshake; a new load below overrides this.
         if (kp_valid_q && m_axis_kp_tready) begin
            kp_valid_d = 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (gpio_io_i == START_CODE) begin
                  state_d    = ST_CMD;
                  word_cnt_d = '0;
                  kp_count_d = '0;
                  err_len_d  = 1'b0;
               end
            end
            ST_CMD: begin
               if (m_axis_mm2s_cmd_tready) begin
                  state_d = ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (wordAccept) begin
                  word_cnt_d = word_cnt_q + 13'd1;
                  if (wordKeep) begin
                     kp_valid_d = 1'b1;
                     kp_data_d  = {3'b0, word_cnt_q, s_axis_mm2s_tdata[23:0]};
                     if (kp_count_q != KP_MAX) begin
                        kp_count_d = kp_count_q + 13'd1;
                     end
                  end
                  // Only tlast landing exactly on the final index is a clean end.
                  if (frameEnd) begin
                     state_d = ST_DRAIN;
                     if (!(s_axis_mm2s_tlast && atLastIdx)) begin
                        err_len_d = 1'b1;
                     end
                  end
               end
            end
            ST_DRAIN: begin
               if (!kp_valid_q) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         word_cnt_q <= '0;
         kp_count_q <= '0;
         err_len_q  <= 1'b0;
         kp_valid_q <= 1'b0;
         kp_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         kp_count_q <= kp_count_d;
         err_len_q  <= err_len_d;
         kp_valid_q <= kp_valid_d;
         kp_data_q  <= kp_data_d;
      end
   end

endmodule

// File: tb/tb_result_fetch.sv
// Self-checking bench for result_fetch: randomized result frames are compared against a
// filtering model that works on whole frames held in arrays and queues.
module tb_result_fetch;

   localparam int          NUMW  = 4800;
   localparam logic [15:0] THR   = 16'h0100;
   localparam logic [7:0]  DUST  = 8'd64;
   localparam logic [31:0] START = 32'h0000_00BB;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] gpio_io_i;
   logic [31:0] gpio_io_o;
   logic        m_axis_mm2s_cmd_tvalid;
   logic        m_axis_mm2s_cmd_tready;
   logic [71:0] m_axis_mm2s_cmd_tdata;
   logic [31:0] s_axis_mm2s_tdata;
   logic        s_axis_mm2s_tvalid;
   logic        s_axis_mm2s_tlast;
   logic        s_axis_mm2s_tready;
   logic [39:0] m_axis_kp_tdata;
   logic        m_axis_kp_tvalid;
   logic        m_axis_kp_tready;

   int vectors    = 0;
   int miscompares = 0;

   logic [31:0] srcData [0:NUMW-1];
   logic        srcLast [0:NUMW-1];
   logic [39:0] gotQ[$];
   logic [39:0] expQ[$];
   logic        expErr;
   int          expCount;

   result_fetch dut (
      .clk                    (clk),
      .rstn                   (rstn),
      .gpio_io_i              (gpio_io_i),
      .gpio_io_o              (gpio_io_o),
      .m_axis_mm2s_cmd_tvalid (m_axis_mm2s_cmd_tvalid),
      .m_axis_mm2s_cmd_tready (m_axis_mm2s_cmd_tready),
      .m_axis_mm2s_cmd_tdata  (m_axis_mm2s_cmd_tdata),
      .s_axis_mm2s_tdata      (s_axis_mm2s_tdata),
      .s_axis_mm2s_tvalid     (s_axis_mm2s_tvalid),
      .s_axis_mm2s_tlast      (s_axis_mm2s_tlast),
      .s_axis_mm2s_tready     (s_axis_mm2s_tready),
      .m_axis_kp_tdata        (m_axis_kp_tdata),
      .m_axis_kp_tvalid       (m_axis_kp_tvalid),
      .m_axis_kp_tready       (m_axis_kp_tready)
   );

   always #5 clk = ~clk;

   // Keep a cell if it is not the dustbin and clears the threshold, up to the frame-ending word.
   function automatic void buildExpected(input int n);
      int endIdx;
      logic [7:0]  id;
      logic [15:0] p;
      endIdx = -1;
      expQ.delete();
      for (int i = 0; i < n; i++) begin
         id = srcData[i][23:16];
         p  = srcData[i][15:0];
         if (id != DUST && p >= THR) expQ.push_back({3'b0, 13'(i), id, p});
         if (srcLast[i] || i == NUMW - 1) begin
            endIdx = i;
            break;
         end
      end
      expErr   = (endIdx < 0) ? 1'b0 : !(endIdx == NUMW - 1 && srcLast[endIdx]);
      expCount = expQ.size();
   endfunction

   function automatic logic [31:0] randWord();
      logic [7:0]  id;
      logic [15:0] p;
      case ($urandom_range(3))
         0:       id = DUST;
         1:       id = 8'd3;
         default: id = 8'($urandom);
      endcase
      if ($urandom_range(1) == 0) p = 16'($urandom);
      else                        p = THR - 16'd2 + 16'($urandom_range(4));
      return {8'($urandom), id, p};
   endfunction

   task automatic clearLast();
      for (int i = 0; i < NUMW; i++) srcLast[i] = 1'b0;
   endtask

   task automatic doStart(output bit timedOut);
      timedOut = 1'b1;
      @(negedge clk);
      gpio_io_i = 32'd0;
      @(negedge clk);
      gpio_io_i = START;
      m_axis_mm2s_cmd_tready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         #1;
         if (m_axis_mm2s_cmd_tvalid) begin
            timedOut = 1'b0;
            break;
         end
      end
      @(negedge clk);
      m_axis_mm2s_cmd_tready = 1'b0;
   endtask

   // Drives n words with random valid gaps, a randomly ready sink and an optional stall window.
   task automatic streamFrame(input int n, input int validPct, input int readyPct,
                              input int stallFrom, input int stallLen, input bit waitDone,
                              output bit timedOut, output int stallViol);
      int cyc;
      int idx;
      bit sent;
      bit holding;
      logic [39:0] held;
      cyc = 0; idx = 0; sent = 1'b0; holding = 1'b0; held = '0;
      timedOut = 1'b0; stallViol = 0;
      gotQ.delete();
      s_axis_mm2s_tvalid = 1'b0;
      forever begin
         @(negedge clk);
         if (sent || !s_axis_mm2s_tvalid) begin
            s_axis_mm2s_tvalid = 1'b0;
            if (idx < n && $urandom_range(99) < validPct) begin
               s_axis_mm2s_tvalid = 1'b1;
               s_axis_mm2s_tdata  = srcData[idx];
               s_axis_mm2s_tlast  = srcLast[idx];
            end
         end
         if (cyc >= stallFrom && cyc < stallFrom + stallLen) m_axis_kp_tready = 1'b0;
         else m_axis_kp_tready = ($urandom_range(99) < readyPct);
         #1;
         sent = s_axis_mm2s_tvalid && s_axis_mm2s_tready;
         if (sent) idx++;
         if (m_axis_kp_tvalid && holding && m_axis_kp_tdata !== held) stallViol++;
         if (m_axis_kp_tvalid && !m_axis_kp_tready && s_axis_mm2s_tready) stallViol++;
         if (m_axis_kp_tvalid && m_axis_kp_tready) begin
            gotQ.push_back(m_axis_kp_tdata);
            holding = 1'b0;
         end else if (m_axis_kp_tvalid) begin
            holding = 1'b1;
            held    = m_axis_kp_tdata;
         end else begin
            holding = 1'b0;
         end
         cyc++;
         if (waitDone ? gpio_io_o[1] : (idx >= n)) break;
         if (cyc > n * 8 + 200) begin
            timedOut = 1'b1;
            break;
         end
      end
      @(negedge clk);
      s_axis_mm2s_tvalid = 1'b0;
      m_axis_kp_tready   = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      gpio_io_i = 32'd0;
      m_axis_mm2s_cmd_tready = 1'b0;
      s_axis_mm2s_tvalid = 1'b0;
      s_axis_mm2s_tlast = 1'b0;
      s_axis_mm2s_tdata = 32'd0;
      m_axis_kp_tready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (gpio_io_o !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_gpio got=%h want=0", gpio_io_o);
      end
      vectors++;
      if ({m_axis_mm2s_cmd_tvalid, s_axis_mm2s_tready, m_axis_kp_tvalid} !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL reset_valids got=%b want=000",
                  {m_axis_mm2s_cmd_tvalid, s_axis_mm2s_tready, m_axis_kp_tvalid});
      end
      vectors++;
      if (m_axis_kp_tdata !== 40'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_kpdata got=%h want=0", m_axis_kp_tdata);
      end
      rstn = 1'b1;
   endtask

   task automatic test_cmd();
      int highCnt;
      int beats;
      logic [71:0] expCmd;
      expCmd = {8'h00, 32'h7000_0000, 1'b1, 1'b1, 6'd0, 1'b1, 23'(NUMW * 4)};
      highCnt = 0; beats = 0;
      @(negedge clk);
      gpio_io_i = START;
      m_axis_mm2s_cmd_tready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         if (m_axis_mm2s_cmd_tvalid) highCnt++;
      end
      vectors++;
      if (gpio_io_o[1:0] !== 2'b01) begin
         miscompares++;
         $display("[TB] FAIL cmd_busy got=%b want=01", gpio_io_o[1:0]);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         m_axis_mm2s_cmd_tready = 1'b1;
         #1;
         if (m_axis_mm2s_cmd_tvalid && m_axis_mm2s_cmd_tready) beats++;
      end
      m_axis_mm2s_cmd_tready = 1'b0;
      vectors++;
      if (highCnt != 5) begin
         miscompares++;
         $display("[TB] FAIL cmd_stall_valid got=%0d want=5", highCnt);
      end
      vectors++;
      if (beats != 1) begin
         miscompares++;
         $display("[TB] FAIL cmd_beats got=%0d want=1", beats);
      end
      vectors++;
      if (m_axis_mm2s_cmd_tdata !== expCmd) begin
         miscompares++;
         $display("[TB] FAIL cmd_tdata got=%h want=%h", m_axis_mm2s_cmd_tdata, expCmd);
      end
   endtask

   task automatic test_full_frame();
      bit to;
      int viol;
      clearLast();
      for (int i = 0; i < NUMW; i++) srcData[i] = {8'($urandom), DUST, 16'($urandom)};
      srcData[0]    = {8'h00, 8'd3, 16'h0200};
      srcData[17]   = {8'h5A, 8'd3, 16'h0200};
      srcData[4799] = {8'hFF, 8'd3, 16'h0200};
      srcLast[NUMW-1] = 1'b1;
      buildExpected(NUMW);
      doStart(to);
      streamFrame(NUMW, 85, 85, 0, 0, 1'b1, to, viol);
      vectors++;
      if (to) begin
         miscompares++;
         $display("[TB] FAIL full_timeout got=timeout want=done");
      end
      vectors++;
      if (gotQ.size() != 3) begin
         miscompares++;
         $display("[TB] FAIL full_kp_num got=%0d want=3", gotQ.size());
      end
      for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
         vectors++;
         if (gotQ[i] !== expQ[i]) begin
            miscompares++;
            $display("[TB] FAIL full_kp%0d got=%h want=%h", i, gotQ[i], expQ[i]);
         end
      end
      vectors++;
      if (gpio_io_o !== {3'b0, 13'd3, 13'b0, 3'b010}) begin
         miscompares++;
         $display("[TB] FAIL full_status got=%h want=%h", gpio_io_o,
                  {3'b0, 13'd3, 13'b0, 3'b010});
      end
   endtask

   task automatic test_threshold();
      bit to;
      int viol;
      logic [31:0] pat [0:7];
      pat[0] = {8'h00, 8'd5,   THR};
      pat[1] = {8'h00, 8'd5,   THR - 16'd1};
      pat[2] = {8'h00, DUST,   THR};
      pat[3] = {8'h00, DUST,   16'hFFFF};
      pat[4] = {8'hAA, 8'd255, 16'hFFFF};
      pat[5] = {8'h00, 8'd0,   16'h0000};
      pat[6] = {8'h00, 8'd63,  THR + 16'd1};
      pat[7] = {8'h11, 8'd65,  THR};
      clearLast();
      for (int i = 0; i < 8; i++) srcData[i] = pat[i];
      srcLast[7] = 1'b1;
      buildExpected(8);
      doStart(to);
      streamFrame(8, 100, 100, 0, 0, 1'b1, to, viol);
      vectors++;
      if (to || gotQ.size() != expQ.size()) begin
         miscompares++;
         $display("[TB] FAIL thr_kp_num got=%0d want=%0d", gotQ.size(), expQ.size());
      end
      for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
         vectors++;
         if (gotQ[i] !== expQ[i]) begin
            miscompares++;
            $display("[TB] FAIL thr_kp%0d got=%h want=%h", i, gotQ[i], expQ[i]);
         end
      end
      repeat (3) @(negedge clk);
      #1;
      vectors++;
      if (gpio_io_o !== {3'b0, 13'(expCount), 13'b0, expErr, 2'b10} || m_axis_mm2s_cmd_tvalid) begin
         miscompares++;
         $display("[TB] FAIL thr_done_hold got=%h cmd=%b want=%h cmd=0", gpio_io_o,
                  m_axis_mm2s_cmd_tvalid, {3'b0, 13'(expCount), 13'b0, expErr, 2'b10});
      end
   endtask

   task automatic test_backpressure();
      bit to;
      int viol;
      clearLast();
      for (int i = 0; i < 300; i++) begin
         srcData[i] = ($urandom_range(4) == 0) ? randWord() :
                      {8'($urandom), 8'($urandom_range(63)), THR + 16'($urandom_range(1000))};
      end
      srcLast[299] = 1'b1;
      buildExpected(300);
      doStart(to);
      streamFrame(300, 100, 70, 20, 10, 1'b1, to, viol);
      vectors++;
      if (to || viol != 0) begin
         miscompares++;
         $display("[TB] FAIL bp_stall got=%0d violations timeout=%0d want=0", viol, to);
      end
      vectors++;
      if (gotQ.size() != expQ.size()) begin
         miscompares++;
         $display("[TB] FAIL bp_kp_num got=%0d want=%0d", gotQ.size(), expQ.size());
      end
      for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
         vectors++;
         if (gotQ[i] !== expQ[i]) begin
            miscompares++;
            $display("[TB] FAIL bp_kp%0d got=%h want=%h", i, gotQ[i], expQ[i]);
         end
      end
      vectors++;
      if (gpio_io_o[28:16] !== 13'(expCount)) begin
         miscompares++;
         $display("[TB] FAIL bp_count got=%0d want=%0d", gpio_io_o[28:16], expCount);
      end
   endtask

   task automatic test_length_errors();
      bit to;
      int viol;
      int lens [0:1];
      lens[0] = 100;
      lens[1] = NUMW;
      for (int t = 0; t < 2; t++) begin
         clearLast();
         for (int i = 0; i < lens[t]; i++) srcData[i] = randWord();
         if (t == 0) srcLast[99] = 1'b1;
         buildExpected(lens[t]);
         doStart(to);
         streamFrame(lens[t], 90, 90, 0, 0, 1'b1, to, viol);
         vectors++;
         if (to || gpio_io_o !== {3'b0, 13'(expCount), 13'b0, 1'b1, 2'b10}) begin
            miscompares++;
            $display("[TB] FAIL len_status%0d got=%h want=%h", t, gpio_io_o,
                     {3'b0, 13'(expCount), 13'b0, 1'b1, 2'b10});
         end
         vectors++;
         if (gotQ.size() != expQ.size()) begin
            miscompares++;
            $display("[TB] FAIL len_kp_num%0d got=%0d want=%0d", t, gotQ.size(), expQ.size());
         end else begin
            for (int i = 0; i < gotQ.size(); i++) begin
               vectors++;
               if (gotQ[i] !== expQ[i]) begin
                  miscompares++;
                  $display("[TB] FAIL len%0d_kp%0d got=%h want=%h", t, i, gotQ[i], expQ[i]);
               end
            end
         end
      end
   endtask

   task automatic test_abort();
      bit to;
      int viol;
      clearLast();
      for (int i = 0; i < NUMW; i++) srcData[i] = randWord();
      doStart(to);
      streamFrame(2000, 90, 50, 0, 0, 1'b0, to, viol);
      gpio_io_i = 32'd0;
      m_axis_mm2s_cmd_tready = 1'b0;
      @(negedge clk);
      #1;
      vectors++;
      if (to || {s_axis_mm2s_tready, m_axis_kp_tvalid, m_axis_mm2s_cmd_tvalid} !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL abort_handshakes got=%b timeout=%0d want=000",
                  {s_axis_mm2s_tready, m_axis_kp_tvalid, m_axis_mm2s_cmd_tvalid}, to);
      end
      vectors++;
      if (gpio_io_o !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL abort_gpio got=%h want=0", gpio_io_o);
      end
      @(negedge clk);
      gpio_io_i = START;
      @(negedge clk);
      #1;
      vectors++;
      if (m_axis_mm2s_cmd_tvalid !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL abort_restart_cmd got=%b want=1", m_axis_mm2s_cmd_tvalid);
      end
      clearLast();
      for (int i = 0; i < 20; i++) srcData[i] = randWord();
      srcLast[19] = 1'b1;
      buildExpected(20);
      doStart(to);
      streamFrame(20, 90, 90, 0, 0, 1'b1, to, viol);
      vectors++;
      if (to || gpio_io_o !== {3'b0, 13'(expCount), 13'b0, 1'b1, 2'b10} ||
          gotQ.size() != expQ.size()) begin
         miscompares++;
         $display("[TB] FAIL abort_fresh got=%h kps=%0d want=%h kps=%0d", gpio_io_o,
                  gotQ.size(), {3'b0, 13'(expCount), 13'b0, 1'b1, 2'b10}, expQ.size());
      end
   endtask

   initial begin
      test_reset();
      test_cmd();
      test_full_frame();
      test_threshold();
      test_backpressure();
      test_length_errors();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog got=running want=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
